// File: rtl/act_buf_stream_reader.sv
// act_buf_stream_reader: drains one frame of 16-bit words from one bank of
// the activation BRAM and emits it as an 8-bit AXI-Stream, low byte first,
// then acknowledges the producer's SyncSig ap_vld/ap_ack handshake.
module act_buf_stream_reader #(
  parameter int AWIDTH      = 12,
  parameter int DWIDTH      = 16,
  parameter int FRAME_WORDS = 1536
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              SyncSig_V,
  input  logic              SyncSig_V_ap_vld,
  output logic              SyncSig_V_ap_ack,
  output logic [AWIDTH-1:0] ActBuf_Data_address0,
  output logic              ActBuf_Data_ce0,
  input  logic [DWIDTH-1:0] ActBuf_Data_q0,
  output logic [7:0]        ActOut_V_TDATA,
  output logic              ActOut_V_TVALID,
  input  logic              ActOut_V_TREADY,
  output logic              ActOut_V_TLAST
);

  localparam logic [AWIDTH:0]   READS_PER_FRAME = (AWIDTH+1)'(FRAME_WORDS);
  localparam logic [AWIDTH:0]   LAST_BYTE       = (AWIDTH+1)'(2*FRAME_WORDS-1);
  localparam logic [AWIDTH-1:0] BANK1_BASE      = AWIDTH'(FRAME_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [AWIDTH-1:0] base;        // bank base latched at frame start
  logic [AWIDTH:0]   rd_cnt;      // reads issued this frame, saturates at FRAME_WORDS
  logic [AWIDTH:0]   byte_cnt;    // bytes transferred this frame
  logic              rd_pending;  // read issued last cycle, data on q0 now
  logic [DWIDTH-1:0] fifo_head;   // word currently being unpacked
  logic [DWIDTH-1:0] fifo_tail;
  logic [1:0]        fifo_cnt;

  logic start;
  logic issue;
  logic room;
  logic tvalid;
  logic tlast;
  logic xfer;
  logic pop;
  logic push;
  logic last_xfer;

  // Datapath control: read issue, stream outputs, FIFO push/pop strobes.
  always_comb begin
    start     = (state == ST_IDLE) && SyncSig_V_ap_vld;
    // At most two words buffered or in flight at any time.
    room      = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && !rd_pending);
    issue     = (state == ST_STREAM) && room && (rd_cnt < READS_PER_FRAME);
    tvalid    = (state == ST_STREAM) && (fifo_cnt != 2'd0);
    tlast     = tvalid && (byte_cnt == LAST_BYTE);
    xfer      = tvalid && ActOut_V_TREADY;
    pop       = xfer && byte_cnt[0];
    push      = rd_pending;
    last_xfer = xfer && tlast;

    ActBuf_Data_ce0      = issue;
    ActBuf_Data_address0 = issue ? (base + rd_cnt[AWIDTH-1:0]) : '0;
    ActOut_V_TVALID      = tvalid;
    ActOut_V_TLAST       = tlast;
    ActOut_V_TDATA       = '0;
    if (tvalid) begin
      ActOut_V_TDATA = byte_cnt[0] ? fifo_head[15:8] : fifo_head[7:0];
    end
  end

  // FSM state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and handshake acknowledge.
  always_comb begin
    state_next       = state;
    SyncSig_V_ap_ack = 1'b0;
    case (state)
      ST_IDLE: begin
        if (SyncSig_V_ap_vld) begin
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_xfer) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        SyncSig_V_ap_ack = 1'b1;
        state_next       = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Counters, bank base and the 2-entry word FIFO.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      base       <= '0;
      rd_cnt     <= '0;
      byte_cnt   <= '0;
      rd_pending <= 1'b0;
      fifo_head  <= '0;
      fifo_tail  <= '0;
      fifo_cnt   <= '0;
    end else if (start) begin
      base       <= SyncSig_V ? BANK1_BASE : '0;
      rd_cnt     <= '0;
      byte_cnt   <= '0;
      rd_pending <= 1'b0;
      fifo_cnt   <= '0;
    end else begin
      rd_pending <= issue;
      if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (xfer) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
      // Head always holds the oldest word; a pop shifts the tail forward.
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            fifo_head <= ActBuf_Data_q0;
          end else begin
            fifo_tail <= ActBuf_Data_q0;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_head <= fifo_tail;
          fifo_cnt  <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo_head <= ActBuf_Data_q0;
          end else begin
            fifo_head <= fifo_tail;
            fifo_tail <= ActBuf_Data_q0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_act_buf_stream_reader.sv
// Bench for act_buf_stream_reader: a small-frame instance (4 words) and a
// default-size instance, each with a 1-cycle-latency BRAM model. Expected
// bytes come from a queue built by unpacking the bench's own BRAM contents.
module tb_act_buf_stream_reader;

  localparam int AW  = 12;
  localparam int SFW = 4;
  localparam int LFW = 1536;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // small instance
  logic        vld_s, sync_s, rdy_s, ack_s, ce_s, tv_s, tl_s;
  logic [AW-1:0] addr_s;
  logic [15:0] q_s;
  logic [7:0]  td_s;
  // large instance
  logic        vld_l, sync_l, rdy_l, ack_l, ce_l, tv_l, tl_l;
  logic [AW-1:0] addr_l;
  logic [15:0] q_l;
  logic [7:0]  td_l;

  logic [15:0] mem_s [0:4095];
  logic [15:0] mem_l [0:4095];

  always @(posedge clk) if (ce_s) q_s <= mem_s[addr_s];
  always @(posedge clk) if (ce_l) q_l <= mem_l[addr_l];

  act_buf_stream_reader #(.AWIDTH(AW), .DWIDTH(16), .FRAME_WORDS(SFW)) dut_s (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .SyncSig_V(sync_s), .SyncSig_V_ap_vld(vld_s), .SyncSig_V_ap_ack(ack_s),
    .ActBuf_Data_address0(addr_s), .ActBuf_Data_ce0(ce_s), .ActBuf_Data_q0(q_s),
    .ActOut_V_TDATA(td_s), .ActOut_V_TVALID(tv_s), .ActOut_V_TREADY(rdy_s),
    .ActOut_V_TLAST(tl_s)
  );

  act_buf_stream_reader #(.AWIDTH(AW), .DWIDTH(16), .FRAME_WORDS(LFW)) dut_l (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .SyncSig_V(sync_l), .SyncSig_V_ap_vld(vld_l), .SyncSig_V_ap_ack(ack_l),
    .ActBuf_Data_address0(addr_l), .ActBuf_Data_ce0(ce_l), .ActBuf_Data_q0(q_l),
    .ActOut_V_TDATA(td_l), .ActOut_V_TVALID(tv_l), .ActOut_V_TREADY(rdy_l),
    .ActOut_V_TLAST(tl_l)
  );

  bit sel;  // 0: small instance under test, 1: large instance
  logic          o_ack, o_ce, o_tv, o_tl;
  logic [AW-1:0] o_addr;
  logic [7:0]    o_td;
  assign o_ack  = sel ? ack_l  : ack_s;
  assign o_ce   = sel ? ce_l   : ce_s;
  assign o_tv   = sel ? tv_l   : tv_s;
  assign o_tl   = sel ? tl_l   : tl_s;
  assign o_addr = sel ? addr_l : addr_s;
  assign o_td   = sel ? td_l   : td_s;

  int n_checks, n_fail;
  int cyc, fw, base_exp, issued, xfers, acks, t0;
  int first_ce_cyc, first_ce_addr, last_ce_addr, first_tv_cyc, last_xfer_cyc, ack_cyc;
  logic [7:0] exp_q[$];
  bit         prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit vld, input bit sync, input bit rdy);
    if (sel) begin
      vld_l = vld; sync_l = sync; rdy_l = rdy;
      vld_s = 1'b0; sync_s = 1'b0; rdy_s = 1'b1;
    end else begin
      vld_s = vld; sync_s = sync; rdy_s = rdy;
      vld_l = 1'b0; sync_l = 1'b0; rdy_l = 1'b1;
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, sample outputs, score them.
  task automatic cycle(input bit vld, input bit sync, input bit rdy);
    logic [7:0] b;
    @(negedge clk);
    drive(vld, sync, rdy);
    #1;
    cyc++;
    if (prev_stall) begin
      check("stall_valid", o_tv, 1);
      check("stall_data", o_td, prev_data);
      check("stall_last", o_tl, prev_last);
    end
    if (o_ce) begin
      check("rd_addr", o_addr, base_exp + issued);
      check("rd_count_ok", issued < fw, 1);
      if (issued == 0) begin
        first_ce_cyc  = cyc;
        first_ce_addr = o_addr;
      end
      last_ce_addr = o_addr;
      issued++;
      check("outstanding_le2", (issued - xfers / 2) <= 2, 1);
    end
    if (o_tv && first_tv_cyc < 0) first_tv_cyc = cyc;
    if (o_tv && rdy) begin
      if (exp_q.size() == 0) begin
        check("extra_byte", o_tv, 0);
      end else begin
        b = exp_q.pop_front();
        check("tdata", o_td, b);
        check("tlast", o_tl, exp_q.size() == 0);
      end
      xfers++;
      last_xfer_cyc = cyc;
    end
    if (o_ack) begin
      acks++;
      ack_cyc = cyc;
    end
    prev_stall = o_tv && !rdy;
    prev_data  = o_td;
    prev_last  = o_tl;
  endtask

  task automatic setup_frame(input int bank, input int nfw);
    logic [15:0] word;
    fw = nfw; base_exp = bank ? nfw : 0;
    issued = 0; xfers = 0; acks = 0; ack_cyc = -1;
    first_tv_cyc = -1; first_ce_cyc = -1; last_xfer_cyc = -1;
    prev_stall = 1'b0;
    exp_q.delete();
    for (int w = 0; w < nfw; w++) begin
      word = sel ? mem_l[base_exp + w] : mem_s[base_exp + w];
      exp_q.push_back(word[7:0]);
      exp_q.push_back(word[15:8]);
    end
  endtask

  task automatic run_frame(input int bank, input int nfw, input bit bp, input bit b2b_next);
    int budget;
    setup_frame(bank, nfw);
    t0 = cyc + 1;
    budget = 12 * nfw + 50;
    cycle(1'b1, bank[0], bp ? 1'($urandom_range(0, 1)) : 1'b1);
    while (acks == 0 && budget > 0) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), bp ? 1'($urandom_range(0, 1)) : 1'b1);
      budget--;
    end
    check("frame_ack_seen", acks, 1);
    check("bytes_left", exp_q.size(), 0);
    check("reads_issued", issued, nfw);
    check("bytes_sent", xfers, 2 * nfw);
    check("first_read_cyc", first_ce_cyc - t0, 1);
    check("first_read_addr", first_ce_addr, base_exp);
    check("last_read_addr", last_ce_addr, base_exp + nfw - 1);
    check("ack_after_last", ack_cyc - last_xfer_cyc, 1);
    if (!bp) begin
      check("first_byte_cyc", first_tv_cyc - t0, 3);
      check("ack_cyc", ack_cyc - t0, 3 + 2 * nfw);
    end
    if (!b2b_next) begin
      cycle(1'b0, 1'b0, 1'b1);
      check("ack_one_cycle", o_ack, 0);
      check("idle_tvalid", o_tv, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_s[i] = 16'($urandom);
      mem_l[i] = 16'($urandom);
    end
    mem_s[0] = 16'h1100; mem_s[1] = 16'h3322;
    mem_s[2] = 16'h5544; mem_s[3] = 16'h7766;

    // Reset and idle
    sel = 1'b0;
    fw = 0; issued = 0;
    drive(1'b0, 1'b0, 1'b1);
    #1;
    check("rst_small_outputs", {ack_s, ce_s, tv_s, tl_s, td_s, addr_s}, 0);
    check("rst_large_outputs", {ack_l, ce_l, tv_l, tl_l, td_l, addr_l}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      check("idle_outputs", {o_ack, o_ce, o_tv, o_tl, o_td, o_addr}, 0);
    end
    check("idle_large_outputs", {ack_l, ce_l, tv_l, tl_l, td_l, addr_l}, 0);

    // Single frame, bank 0, no backpressure
    run_frame(0, SFW, 1'b0, 1'b0);
    // Random backpressure, bank 0 and bank 1
    for (int i = 0; i < 4; i++) run_frame(0, SFW, 1'b1, 1'b0);
    run_frame(1, SFW, 1'b1, 1'b0);

    // Back-to-back frames with bank toggling, vld held through ack
    run_frame(0, SFW, 1'b0, 1'b1);
    run_frame(1, SFW, 1'b0, 1'b1);
    run_frame(0, SFW, 1'b1, 1'b0);

    // Reset mid-frame after 3 bytes
    begin
      int budget;
      budget = 30;
      setup_frame(0, SFW);
      cycle(1'b1, 1'b0, 1'b1);
      while (xfers < 3 && budget > 0) begin
        cycle(1'b1, 1'b0, 1'b1);
        budget--;
      end
      check("pre_reset_bytes", xfers, 3);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midframe_rst_outputs", {o_ack, o_ce, o_tv, o_tl, o_td, o_addr}, 0);
      fw = 0; issued = 0; prev_stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
        cycle(1'b0, 1'b0, 1'b1);
        check("in_reset_outputs", {o_ack, o_ce, o_tv, o_tl, o_td, o_addr}, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        cycle(1'b0, 1'b0, 1'b1);
        check("post_reset_no_ack", o_ack, 0);
      end
      run_frame(0, SFW, 1'b0, 1'b0);
    end

    // Default frame size: bank 1 straight, bank 0 with backpressure
    sel = 1'b1;
    fw = 0; issued = 0; prev_stall = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    check("large_idle_outputs", {o_ack, o_ce, o_tv, o_tl, o_td, o_addr}, 0);
    run_frame(1, LFW, 1'b0, 1'b0);
    check("large_first_addr", first_ce_addr, 1536);
    check("large_last_addr", last_ce_addr, 3071);
    check("large_byte_count", xfers, 3072);
    run_frame(0, LFW, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/act_buf_stream_reader.md
# act_buf_stream_reader

Drains one frame of packed activations from a layer's dual-port activation BRAM and emits it as an 8-bit AXI-Stream, one byte per beat. It is the read-side counterpart of the layer write-activation block: the writer fills the BRAM, raises the SyncSig ap_vld/ap_ack handshake, and this block streams the frame out and acknowledges when done. It sits between a layer's activation buffer and the next layer's `ActDMA` input, or a DMA write-back channel.

## Interface
Parameters:
- `AWIDTH`, 12: BRAM address width.
- `DWIDTH`, 16: BRAM word width. Fixed at 2 bytes per word.
- `FRAME_WORDS`, 1536: words per frame and per bank. Requires `2*FRAME_WORDS <= 2**AWIDTH`.

Ports:
- `ap_clk`  in  1  the single clock; all logic is on the rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `SyncSig_V`  in  1  bank select. 0 gives base address 0; 1 gives base address `FRAME_WORDS`.
- `SyncSig_V_ap_vld`  in  1  the producer holds this high while a frame is ready.
- `SyncSig_V_ap_ack`  out  1  one-cycle pulse after the last byte of the frame is accepted.
- `ActBuf_Data_address0`  out  AWIDTH  BRAM read address.
- `ActBuf_Data_ce0`  out  1  BRAM read enable.
- `ActBuf_Data_q0`  in  DWIDTH  BRAM read data. Valid 1 cycle after the cycle in which `ce0` is high.
- `ActOut_V_TDATA`  out  8  output byte.
- `ActOut_V_TVALID`  out  1  output valid.
- `ActOut_V_TREADY`  in  1  downstream ready.
- `ActOut_V_TLAST`  out  1  high on the final byte of the frame.

## Operation
FSM states:
- IDLE:
  - Ack is 0.
  - When `ap_vld` is 1, latch the base address from `SyncSig_V` and go to STREAM.
  - `SyncSig_V` is ignored at all other times.
- STREAM:
  - Reads words `base .. base+FRAME_WORDS-1` in ascending order.
  - A read is issued (`ce0=1`, address = next word) only if (words held in the 2-entry word FIFO + reads in flight) < 2, and fewer than `FRAME_WORDS` reads have been issued.
  - `q0` is pushed into the FIFO on the cycle it is valid.
  - Each word is unpacked low byte first: `[7:0]`, then `[15:8]`.
  - `TLAST` is 1 only on byte index `2*FRAME_WORDS-1`.
  - When that byte is transferred (`TVALID & TREADY & TLAST`), go to DONE.
- DONE:
  - `ap_ack=1` for exactly one cycle, then return to IDLE.
  - The producer's vld/ack transfer completes in this cycle. A `vld` seen in the following IDLE cycle is a new frame.

Rules:
- `ce0` is never high outside STREAM.
- Exactly `FRAME_WORDS` reads are issued per frame, with no duplicate or skipped addresses.
- The byte counter is `AWIDTH+1` bits. The read counter does not wrap: it stops at `FRAME_WORDS`.

AXI-Stream rules:
- Once `TVALID` is 1, `TDATA`, `TLAST` and `TVALID` hold until `TREADY` is 1.
- `TVALID` does not depend combinationally on `TREADY`.

Reset: while `ap_rst_n=0`, regardless of state (including mid-frame):
- FSM returns to IDLE.
- FIFO and counters are cleared and in-flight reads are discarded.
- No ack is issued for the aborted frame.

## Timing
Reset values: `SyncSig_V_ap_ack=0`, `ActBuf_Data_ce0=0`, `ActBuf_Data_address0=0`, `ActOut_V_TDATA=0`, `ActOut_V_TVALID=0`, `ActOut_V_TLAST=0`.

Start latency, with IDLE sampling `vld=1` in cycle T:
- T+1: `ce0=1`, `address=base`.
- T+2: `q0` valid and captured.
- T+3: `TVALID=1` with byte 0.

Throughput:
- With `TREADY` held at 1, there is one byte per cycle with no bubbles until `TLAST`.
- Reads are issued at most every other cycle in steady state.

End of frame:
- Last transfer in cycle X; `ack=1` in X+1; IDLE in X+2.
- The earliest next-frame read is X+3.

Stall: when `TREADY=0`, no more than 2 words are buffered or in flight, so reads stop.

## Test plan
- Reset / idle: assert reset, then release with `vld=0` for 20 cycles. All outputs are 0; `ce0` is never 1.
- Single frame, bank 0:
  - Stimulus: `FRAME_WORDS=4`, BRAM[0..3] = 0x1100, 0x3322, 0x5544, 0x7766, `TREADY=1`, `vld` at T.
  - Required: bytes 0x00..0x77 in order on cycles T+3..T+10; `TLAST` only on 0x77; `ack` pulse at T+11; reads at addresses 0..3 only.
- Random backpressure (50% `TREADY`), same frame:
  - Byte sequence is identical.
  - `TDATA`/`TLAST` are stable during every stall.
  - Words buffered plus in flight never exceed 2.
- Bank 1 (`SyncSig_V=1`, default `FRAME_WORDS`): the first read address is 1536 and the last is 3071. The frame ends with exactly 3072 bytes, `TLAST` on byte 3071.
- Back-to-back frames: `vld` held high through the ack cycle with `SyncSig_V` toggled. The second frame starts from the other bank with exactly one IDLE cycle between.
- Reset mid-frame: assert `ap_rst_n=0` after 3 bytes. Outputs return to reset values immediately, with no ack. After release, a new `vld` restarts at the base address with byte 0.
